muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles and holds the products and quotients in the architectural HI/LO registers. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. The busy flag drives the hazard unit's stall logic.

## Interface
- WIDTH, 32, operand and HI/LO width in bits (≥ 8)
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥ 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥ 1)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- start  input  1  one-cycle request; op/A/B sampled at the same edge
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6–7 reserved (no-op)
- A  input  WIDTH  rs operand (forwarded value)
- B  input  WIDTH  rt operand (forwarded value)
- busy  output  1  registered; high while an operation is in flight
- hi  output  WIDTH  registered HI register
- lo  output  WIDTH  registered LO register

## Operation
- State: idle / running, plus a down-counter of width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)), pending_hi, pending_lo, hi, lo. busy = (counter != 0).
- Accepted start (start=1 and busy=0 at an edge):
  - MULT: {pending_hi,pending_lo} = signed(A) × signed(B), 2·WIDTH result; counter ← MULT_CYCLES.
  - MULTU: same, unsigned.
  - DIV: pending_lo = signed quotient truncated toward zero; pending_hi = remainder carrying the sign of A; counter ← DIV_CYCLES.
  - DIVU: unsigned quotient/remainder.
  - MTHI: hi ← A at this edge; busy stays 0; lo unchanged.
  - MTLO: lo ← A at this edge; busy stays 0; hi unchanged.
  - reserved op: no state change.
- Results are computed at the accept edge into the pending registers. A and B need not be held afterwards.
- Division by zero (B=0): pending_lo = all ones; pending_hi = A. This is fixed and identical for DIV and DIVU.
- Signed overflow (DIV with A = most-negative and B = all ones): pending_lo = A, pending_hi = 0.
- Ignored start: start while busy=1 is ignored with no state change. The hazard unit stalls, so this is an error case only, and the in-flight operation proceeds.
- Each edge with counter > 0 decrements it. On the 1→0 transition, hi ← pending_hi and lo ← pending_lo.

## Timing
- Reset (reset=0, async): busy=0, hi=0, lo=0, counter=0, pending=0. An in-flight operation is discarded and HI/LO are not written.
- Accept at edge E0 for MULT*: busy=1 after E0 through edge E0+MULT_CYCLES. At that edge hi/lo update and busy falls together. New hi/lo are visible in the first cycle busy=0.
- DIV*: identical, with DIV_CYCLES.
- MTHI/MTLO: value visible on hi/lo the cycle after the accept edge. Zero busy cycles.
- Back-to-back: start may be accepted in the first cycle busy=0, i.e. at edge E0+N. Its hi/lo write from the previous op lands on that same edge. The new op's computation uses the A/B inputs, not HI/LO, so there is no conflict.
- hi/lo hold their old values throughout busy, so MFHI/MFLO reads during busy (if not stalled) return the pre-op value.
- No combinational path from inputs to any output.

## Test plan
- Reset mid-operation: MULTU A=3, B=5; drop reset at cycle 2 → busy=0, hi=0, lo=0 immediately. After release with no start, hi and lo stay 0.
- Signed multiply (WIDTH=32, MULT_CYCLES=5): MULT A=0xFFFFFFFE (−2), B=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- Signed divide (DIV_CYCLES=10): DIV A=−7, B=2 → busy exactly 10 cycles, lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU A=7, B=2 → lo=3, hi=1.
- Divide corner cases: DIVU A=0x1234, B=0 → lo=0xFFFFFFFF, hi=0x1234. DIV A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI/MTLO and ignored start: MTHI A=0xAAAA then MTLO A=0x5555 on consecutive cycles → hi=0xAAAA, lo=0x5555, busy never asserted. Start MULT A=2, B=2 and pulse MTLO A=9 two cycles later → MTLO is ignored; final lo=4, hi=0.
- Back-to-back and parametrisation: MULTU 2×3, then DIVU 9/2 in the first busy=0 cycle → lo=6 in that cycle, then lo=4, hi=1 after DIV_CYCLES. Rerun with WIDTH=16, MULT_CYCLES=1: MULTU 0xFFFF×0xFFFF → busy 1 cycle, hi=0xFFFE, lo=0x0001.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at the accept edge and committed to HI/LO when the busy countdown expires.
module muldiv_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;
    logic               div_signed, a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   dvd, dvs, q_mag, r_mag, div_quo, div_rem;

    // Full-width products; low 2*WIDTH bits of the sign-extended product are the signed result.
    always_comb begin
        a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
        b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
        prod_s = a_sx * b_sx;
        prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    end

    // One unsigned divider on magnitudes; most-negative / -1 naturally yields quotient A, remainder 0.
    always_comb begin
        div_signed = (op == OP_DIV);
        a_neg      = div_signed & A[WIDTH-1];
        b_neg      = div_signed & B[WIDTH-1];
        div_zero   = (B == '0);
        dvd        = a_neg ? (~A + WIDTH'(1)) : A;
        dvs        = b_neg ? (~B + WIDTH'(1)) : B;
        q_mag      = div_zero ? '0 : dvd / dvs;
        r_mag      = div_zero ? '0 : dvd % dvs;
        div_quo    = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
        div_rem    = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
        if (div_zero) begin
            div_quo = '1;
            div_rem = A;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = div_rem;
                            pend_lo_d = div_quo;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = ST_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a transaction-level arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    logic        start16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16;
    logic [15:0] hi16, lo16;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) u_dut16 (
        .clk(clk), .reset(rst_n), .start(start16), .op(op16), .A(a16), .B(b16),
        .busy(busy16), .hi(hi16), .lo(lo16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Architectural result of one operation on 32-bit operands, from sign/magnitude arithmetic.
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   inout logic [31:0] rh, inout logic [31:0] rl, output int cyc);
        longint      sx, sy, mx, my, q, r, p;
        logic [63:0] pu;
        cyc = 0;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                rh = p[63:32]; rl = p[31:0]; cyc = 5;
            end
            3'd1: begin
                pu = {32'b0, x} * {32'b0, y};
                rh = pu[63:32]; rl = pu[31:0]; cyc = 5;
            end
            3'd2: begin
                cyc = 10;
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF;
                end else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    mx = (sx < 0) ? -sx : sx;
                    my = (sy < 0) ? -sy : sy;
                    q = mx / my;
                    r = mx % my;
                    if ((sx < 0) != (sy < 0)) q = -q;
                    if (sx < 0) r = -r;
                    rh = r[31:0]; rl = q[31:0];
                end
            end
            3'd3: begin
                cyc = 10;
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF;
                end else begin
                    rh = x % y; rl = x / y;
                end
            end
            3'd4: rh = x;
            3'd5: rl = x;
            default: ;
        endcase
    endfunction

    // Drive a one-cycle start at the current negedge; operands are scrambled afterwards.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] old_hi,
                             input logic [31:0] old_lo, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        int   n;
        logic held_bad;
        n = 0;
        held_bad = 1'b0;
        while (busy && n < 100) begin
            if (hi !== old_hi || lo !== old_lo) held_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_hold"}, 64'(held_bad), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
        logic [31:0] old_hi, old_lo;
        int          cyc;
        old_hi = m_hi;
        old_lo = m_lo;
        ref_op(o, x, y, m_hi, m_lo, cyc);
        issue(o, x, y);
        if (cyc == 0) begin
            chk({tag, "_busy"}, 64'(busy), 64'd0);
            chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
            chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
        end else begin
            wait_done(tag, cyc, old_hi, old_lo, m_hi, m_lo);
        end
    endtask

    task automatic run16(input string tag, input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y, input int exp_cyc, input logic [15:0] exp_hi,
                         input logic [15:0] exp_lo);
        int n;
        start16 = 1'b1; op16 = o; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0; a16 = '0; b16 = '0;
        n = 0;
        while (busy16 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_hi"}, 64'(hi16), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo16), 64'(exp_lo));
    endtask

    initial begin
        logic [31:0] old_hi, old_lo, rx, ry;
        logic [2:0]  ro;
        int          cyc;

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy16", 64'(busy16), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFFA);
        run("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi_const", 64'(hi), 64'h2);
        run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
        chk("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
        run("divu", 3'd3, 32'd7, 32'd2);
        run("divu_zero", 3'd3, 32'h1234, 32'd0);
        chk("divu_zero_lo_const", 64'(lo), 64'hFFFF_FFFF);
        run("div_zero", 3'd2, 32'h8765_4321, 32'd0);
        run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        run("mthi", 3'd4, 32'hAAAA, 32'd0);
        run("mtlo", 3'd5, 32'h5555, 32'd0);
        run("reserved", 3'd6, 32'hDEAD, 32'hBEEF);

        // MTLO arriving while a MULT is in flight must be dropped.
        old_hi = m_hi; old_lo = m_lo;
        ref_op(3'd0, 32'd2, 32'd2, m_hi, m_lo, cyc);
        issue(3'd0, 32'd2, 32'd2);
        @(negedge clk);
        issue(3'd5, 32'd9, 32'd0);
        wait_done("ignored_mtlo", cyc - 2, old_hi, old_lo, m_hi, m_lo);
        chk("ignored_mtlo_lo_const", 64'(lo), 64'd4);

        // Back-to-back: DIVU issued in the first idle cycle after MULTU.
        run("b2b_multu", 3'd1, 32'd2, 32'd3);
        chk("b2b_lo6", 64'(lo), 64'd6);
        run("b2b_divu", 3'd3, 32'd9, 32'd2);
        chk("b2b_divu_hi_const", 64'(hi), 64'd1);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: begin rx = 32'($urandom_range(0, 255)); ry = 32'($urandom_range(1, 15)); end
                3: ry = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry);
        end

        // Asynchronous reset in the middle of a MULTU.
        run("pre_rst_mthi", 3'd4, 32'h77, 32'd0);
        issue(3'd1, 32'd3, 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (8) @(negedge clk);
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_hi", 64'(hi), 64'd0);
        chk("postrst_lo", 64'(lo), 64'd0);

        run16("w16_multu", 3'd1, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 16'h0001);
        run16("w16_mult", 3'd0, 16'hFFFE, 16'd3, 1, 16'hFFFF, 16'hFFFA);
        run16("w16_div", 3'd2, 16'hFFF9, 16'd2, 10, 16'hFFFF, 16'hFFFD);
        run16("w16_div_ovf", 3'd2, 16'h8000, 16'hFFFF, 10, 16'h0000, 16'h8000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
